// File: rtl/jtag_master.sv
// jtag_master: turns command/response transactions on clk into TCK/TMS/TDI for the on-chip TAP.
// Define JTAG_MASTER_RUNTEST_EN to build the run-idle engine; otherwise op 11 completes at once.
//
// state | meaning
// IDLE  | waiting for a command, tck parked low
// HDR   | TMS walk into Shift-IR/Shift-DR, or the full TAP reset sequence for op 00
// SHIFT | N bits of TDI out / TDO in, TMS high on the last bit
// TRAIL | Exit1 -> Update -> Run-Test/Idle
// RUN   | N TCK cycles with TMS low (run-idle build only)
// RESP  | response held, no TCK activity, until rsp_ready
module jtag_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    localparam int CW = ($clog2(MAX_LEN + 1) > 3) ? $clog2(MAX_LEN + 1) : 3;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
`ifdef JTAG_MASTER_RUNTEST_EN
    localparam logic [2:0] S_RUN   = 3'd4;
`endif
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;

    // Header TMS patterns, LSB is the first TCK cycle.
    localparam logic [6:0] HDR_RESET = 7'b0111111;
    localparam logic [6:0] HDR_IR    = 7'b0000011;
    localparam logic [6:0] HDR_DR    = 7'b0000001;

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [CW-1:0]      r_len_m1;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_rsp;
    logic [6:0]         r_seq;
    logic [DW-1:0]      r_div;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_rsp_valid;

    logic [CW-1:0]      w_len_eff;
    logic [CW-1:0]      w_len_m1;
    logic [IW-1:0]      w_idx_nxt;

    always_comb begin
        w_len_eff = CW'(cmd_len);
        if (cmd_len == 6'd0 || int'(cmd_len) > MAX_LEN)
            w_len_eff = CW'(MAX_LEN);
    end

    assign w_len_m1  = w_len_eff - CW'(1);
    assign w_idx_nxt = r_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_RESET;
            r_len_m1    <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_rsp       <= '0;
            r_seq       <= '0;
            r_div       <= '0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op     <= cmd_op;
                        r_len_m1 <= w_len_m1;
                        r_data   <= cmd_data;
                        r_rsp    <= '0;
                        r_div    <= DIV_LOAD;
                        r_idx    <= '0;
                        r_tdi    <= 1'b0;
                        // The accept edge is also the start of the first low phase.
                        case (cmd_op)
                            OP_RESET: begin
                                r_state <= S_HDR;
                                r_cnt   <= CW'(6);
                                r_tms   <= HDR_RESET[0];
                                r_seq   <= {1'b0, HDR_RESET[6:1]};
                            end
                            OP_IR: begin
                                r_state <= S_HDR;
                                r_cnt   <= CW'(3);
                                r_tms   <= HDR_IR[0];
                                r_seq   <= {1'b0, HDR_IR[6:1]};
                            end
                            OP_DR: begin
                                r_state <= S_HDR;
                                r_cnt   <= CW'(2);
                                r_tms   <= HDR_DR[0];
                                r_seq   <= {1'b0, HDR_DR[6:1]};
                            end
                            default: begin
`ifdef JTAG_MASTER_RUNTEST_EN
                                r_state <= S_RUN;
                                r_cnt   <= w_len_m1;
                                r_tms   <= 1'b0;
`else
                                r_state     <= S_RESP;
                                r_rsp_valid <= 1'b1;
`endif
                            end
                        endcase
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    if (r_div != '0) begin
                        r_div <= r_div - DW'(1);
                    end else begin
                        r_div <= DIV_LOAD;
                        if (!r_tck) begin
                            r_tck <= 1'b1;
                            if (r_state == S_SHIFT)
                                r_rsp[r_idx] <= tdo;
                        end else begin
                            // End of a TCK cycle: set up TMS/TDI for the next low phase.
                            r_tck <= 1'b0;
                            case (r_state)
                                S_HDR: begin
                                    if (r_cnt != '0) begin
                                        r_cnt <= r_cnt - CW'(1);
                                        r_tms <= r_seq[0];
                                        r_seq <= {1'b0, r_seq[6:1]};
                                    end else if (r_op == OP_RESET) begin
                                        r_state     <= S_RESP;
                                        r_rsp_valid <= 1'b1;
                                    end else begin
                                        r_state <= S_SHIFT;
                                        r_cnt   <= r_len_m1;
                                        r_tms   <= (r_len_m1 == '0);
                                        r_tdi   <= r_data[0];
                                    end
                                end
                                S_SHIFT: begin
                                    if (r_cnt != '0) begin
                                        r_cnt <= r_cnt - CW'(1);
                                        r_idx <= w_idx_nxt;
                                        r_tdi <= r_data[w_idx_nxt];
                                        r_tms <= (r_cnt == CW'(1));
                                    end else begin
                                        r_state <= S_TRAIL;
                                        r_cnt   <= CW'(1);
                                        r_tms   <= 1'b1;
                                        r_tdi   <= 1'b0;
                                    end
                                end
                                S_TRAIL: begin
                                    if (r_cnt != '0) begin
                                        r_cnt <= r_cnt - CW'(1);
                                        r_tms <= 1'b0;
                                    end else begin
                                        r_state     <= S_RESP;
                                        r_rsp_valid <= 1'b1;
                                    end
                                end
`ifdef JTAG_MASTER_RUNTEST_EN
                                S_RUN: begin
                                    if (r_cnt != '0) begin
                                        r_cnt <= r_cnt - CW'(1);
                                    end else begin
                                        r_state     <= S_RESP;
                                        r_rsp_valid <= 1'b1;
                                    end
                                end
`endif
                                default: begin
                                    r_state <= S_IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural TAP (IDCODE/BYPASS, 5-bit IR) on the JTAG pins and a
// stream-level model of the expected TMS/TDI sequences, TDO capture, and latency.
module tb_jtag_master;

    localparam int CLK_DIV = 2;
    localparam int MAXL    = 32;

    localparam logic [31:0] IDCODE    = 32'hDEADBEEF;
    localparam logic [4:0]  IR_IDCODE = 5'h02;
    localparam logic [4:0]  IR_BYPASS = 5'h1F;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                   EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                   PAIR = 13, EX2IR = 14, UPIR = 15;

    logic            clk;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [5:0]      cmd_len;
    logic [MAXL-1:0] cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [MAXL-1:0] rsp_data;
    logic            tck;
    logic            tms;
    logic            tdi;
    logic            tdo;

    int n_vec = 0;
    int n_err = 0;

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural TAP ----------------
    int          tap_st = TLR;
    logic [4:0]  tap_ir = IR_IDCODE;
    logic [4:0]  ir_sr  = 5'h0;
    logic [31:0] dr_sr  = 32'h0;
    bit          mon_tms[$];
    bit          mon_tdi[$];

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            TLR:   tap_ir <= IR_IDCODE;
            CAPIR: ir_sr  <= 5'b00001;
            SHIR:  ir_sr  <= {tdi, ir_sr[4:1]};
            UPIR:  tap_ir <= ir_sr;
            CAPDR: dr_sr  <= (tap_ir == IR_BYPASS) ? 32'h0 : IDCODE;
            SHDR:  begin
                if (tap_ir == IR_BYPASS) dr_sr[0] <= tdi;
                else                     dr_sr    <= {tdi, dr_sr[31:1]};
            end
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
        mon_tms.push_back(tms);
        mon_tdi.push_back(tdi);
    end

    initial tdo = 1'b0;
    always @(negedge tck)
        tdo <= (tap_st == SHIR) ? ir_sr[0] : (tap_st == SHDR) ? dr_sr[0] : 1'b0;

    // tms/tdi must never move while tck is high
    int   viol = 0;
    logic p_tms = 1'b1, p_tdi = 1'b0;
    always @(negedge clk) begin
        if (tck === 1'b1 && (tms !== p_tms || tdi !== p_tdi)) viol <= viol + 1;
        p_tms <= tms;
        p_tdi <= tdi;
    end

    // ---------------- reference model ----------------
    logic [4:0] m_ir = IR_IDCODE;

    function automatic logic [31:0] lenmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [5:0] len,
                          input logic [31:0] data, input int hold);
        int           n, w, lat, exp_lat, bad;
        logic [31:0]  cap, exp_rsp, d;
        logic [127:0] s;
        bit           e_tms[$];
        bit           e_tdi[$];
        n = (len == 6'd0 || int'(len) > MAXL) ? MAXL : int'(len);
        d = data & lenmask(n);
        exp_rsp = 32'h0;
        case (op)
            2'b00: begin
                for (int i = 0; i < 7; i++) begin e_tms.push_back(i < 6); e_tdi.push_back(1'b0); end
                m_ir = IR_IDCODE;
            end
            2'b01, 2'b10: begin
                if (op == 2'b01) begin
                    w = 5;  cap = 32'h1;
                    e_tms = '{1, 1, 0, 0};
                end else begin
                    if (m_ir == IR_BYPASS) begin w = 1;  cap = 32'h0; end
                    else                   begin w = 32; cap = IDCODE; end
                    e_tms = '{1, 0, 0};
                end
                foreach (e_tms[i]) e_tdi.push_back(1'b0);
                // TDO stream is the captured register followed by the TDI bits.
                s = ({96'h0, d} << w) | {96'h0, cap};
                exp_rsp = s[31:0] & lenmask(n);
                if (op == 2'b01) m_ir = s[n +: 5];
                for (int k = 0; k < n; k++) begin e_tms.push_back(k == n - 1); e_tdi.push_back(data[k]); end
                e_tms.push_back(1'b1); e_tdi.push_back(1'b0);
                e_tms.push_back(1'b0); e_tdi.push_back(1'b0);
            end
            default: begin
`ifdef JTAG_MASTER_RUNTEST_EN
                for (int k = 0; k < n; k++) begin e_tms.push_back(1'b0); e_tdi.push_back(1'b0); end
`endif
            end
        endcase
        exp_lat = e_tms.size() * 2 * CLK_DIV;

        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
        end
        mon_tms.delete();
        mon_tdi.delete();
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_len = 6'($urandom); cmd_data = $urandom;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++; $display("FAIL latency op=%0d len=%0d: got %0d want %0d", op, len, lat, exp_lat);
        end
        n_vec++;
        if (rsp_data !== exp_rsp) begin
            n_err++; $display("FAIL rsp_data op=%0d len=%0d: got %h want %h", op, len, rsp_data, exp_rsp);
        end
        n_vec++;
        if (mon_tms.size() != e_tms.size()) begin
            n_err++; $display("FAIL tck_count op=%0d len=%0d: got %0d want %0d", op, len, mon_tms.size(), e_tms.size());
        end else begin
            bad = -1;
            for (int i = 0; i < e_tms.size(); i++)
                if (bad < 0 && (mon_tms[i] != e_tms[i] || mon_tdi[i] != e_tdi[i])) bad = i;
            n_vec++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL tms_tdi_seq op=%0d len=%0d cycle %0d: got tms=%0b tdi=%0b want tms=%0b tdi=%0b",
                         op, len, bad, mon_tms[bad], mon_tdi[bad], e_tms[bad], e_tdi[bad]);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            n_vec++;
            if ({rsp_valid, tck, cmd_ready} !== 3'b100 || rsp_data !== exp_rsp) begin
                n_err++;
                $display("FAIL resp_hold cycle %0d: got valid=%b tck=%b ready=%b data=%h want 1 0 0 %h",
                         h, rsp_valid, tck, cmd_ready, rsp_data, exp_rsp);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_data !== exp_rsp) begin
            n_err++;
            $display("FAIL after_consume: got valid=%b ready=%b data=%h want 0 1 %h",
                     rsp_valid, cmd_ready, rsp_data, exp_rsp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 6'd0;
        cmd_data = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid} !== 5'b01010 || rsp_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: got tck/tms/tdi/ready/valid=%b data=%h want 01010 0",
                     {tck, tms, tdi, cmd_ready, rsp_valid}, rsp_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idcode;
        do_cmd(2'b00, 6'd0, $urandom, 0);
        do_cmd(2'b10, 6'd32, 32'h0, 0);
    endtask

    task automatic test_ir_bypass;
        do_cmd(2'b01, 6'd5, 32'h1F, 0);
        do_cmd(2'b10, 6'd8, 32'hA5, 0);
    endtask

    task automatic test_stall;
        do_cmd(2'b10, 6'd8, $urandom, 20);
    endtask

    task automatic test_len_bounds;
        do_cmd(2'b00, 6'd3, 32'h0, 0);
        do_cmd(2'b10, 6'd0, $urandom, 0);
        do_cmd(2'b10, 6'd40, $urandom, 0);
        do_cmd(2'b10, 6'd1, $urandom, 0);
        do_cmd(2'b01, 6'd1, $urandom, 0);
    endtask

    task automatic test_runidle;
        do_cmd(2'b11, 6'd10, $urandom, 0);
        do_cmd(2'b11, 6'd1, $urandom, 0);
    endtask

    task automatic test_random;
        logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            do_cmd(op, 6'($urandom_range(0, 40)), $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 6'd32; cmd_data = $urandom;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3 * 2 * CLK_DIV + 21) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid} !== 5'b01010 || rsp_data !== 32'h0) begin
            n_err++;
            $display("FAIL mid_reset_async: got tck/tms/tdi/ready/valid=%b data=%h want 01010 0",
                     {tck, tms, tdi, cmd_ready, rsp_valid}, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(2'b00, 6'd0, 32'h0, 0);
        do_cmd(2'b10, 6'd32, 32'h0, 0);
    endtask

    task automatic test_pin_stability;
        n_vec++;
        if (viol !== 0) begin
            n_err++; $display("FAIL tms_tdi_stable_while_tck_high: got %0d changes want 0", viol);
        end
    endtask

    initial begin
        test_reset;
        test_idcode;
        test_ir_bypass;
        test_stall;
        test_len_bounds;
        test_runidle;
        test_random;
        test_mid_reset;
        test_pin_stability;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_master.md
# jtag_master

Clock-domain JTAG driver that turns command/response transactions on `clk` into TCK/TMS/TDI waveforms for the on-chip TAP controller, and returns the TDO bits captured during each shift. It sits directly upstream of the TAP and is its only source of TCK, TMS and TDI. Bench sequencers and the debug host bridge use it to run reset, IR-shift, DR-shift and run-idle operations without bit-banging.

## Interface
Parameters:
- `CLK_DIV`, default 4: clk cycles per TCK half-period; legal range ≥ 1.
- `MAX_LEN`, default 32: maximum shift length in bits; sets the width of `cmd_data` and `rsp_data`.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`, in, 2: operation code.
  - 00: TAP reset.
  - 01: IR shift.
  - 10: DR shift.
  - 11: run-idle.
- `cmd_len`, in, 6: number of bits for a shift, or number of TCK cycles for run-idle.
- `cmd_data`, in, MAX_LEN: TDI bits, LSB shifted first.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`, out, MAX_LEN: captured TDO bits, right-aligned.
- `tck`, out, 1: JTAG TCK.
- `tms`, out, 1: JTAG TMS.
- `tdi`, out, 1: JTAG TDI.
- `tdo`, in, 1: JTAG TDO from the TAP.

## Operation
- FSM states: IDLE, HDR, SHIFT, TRAIL, RUN, RESP.
  - IDLE → HDR on command accept. Op 11 goes IDLE → RUN instead.
  - HDR → SHIFT after the header bits.
  - SHIFT → TRAIL after the last shift bit.
  - TRAIL → RESP after the trailer bits.
  - RUN → RESP after the run-idle cycles.
  - RESP → IDLE on `rsp_ready`.
- `cmd_ready` = (state == IDLE). Command fields are latched at accept; later input changes are ignored.
- Effective length: `cmd_len` of 0 or greater than MAX_LEN is treated as MAX_LEN.
- TMS sequences, one TMS value per TCK cycle:
  - Op 00: six 1s then one 0, leaving the TAP in Run-Test/Idle. Header length 7, no SHIFT, no TRAIL. `rsp_data` = 0.
  - Op 01: header 1,1,0,0.
  - Op 10: header 1,0,0.
  - Ops 01 and 10, shift phase: N bits with TMS = 0, except the last bit, which has TMS = 1. Trailer 1,0.
  - Op 11: N cycles with TMS = 0. `rsp_data` = 0.
- Ops 01, 10 and 11 require the TAP to start in Run-Test/Idle. Every op ends in Run-Test/Idle. After `rst_n` the first command must be op 00.
- In shift cycle k (0..N-1), `tdi` = `cmd_data[k]`. TDO sampled at that cycle's rising TCK edge goes to `rsp_data[k]`. Bits above N-1 are 0. Outside shift cycles `tdi` = 0.
- `rsp_data` holds its value until the next command is accepted.

## Timing
- Reset values:
  - `tck` = 0, `tms` = 1, `tdi` = 0.
  - `cmd_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0.
  - State IDLE.
- Each TCK cycle is 2·CLK_DIV clk cycles: low phase first, then high phase.
- `tms` and `tdi` change only on the clk edge that starts a low phase. They are stable for CLK_DIV clk cycles before the rising TCK edge.
- `tdo` is sampled on the clk edge that drives `tck` high.
- Latency from accept (cycle t):
  - First low phase starts at t+1.
  - `rsp_valid` rises on the clk edge ending the last high phase.
  - Total latency = T·2·CLK_DIV clk cycles, where T is the TCK cycle count.
- TCK cycle counts: op 00 → 7; op 01 → N+6; op 10 → N+5; op 11 → N.
- `tck` idles at 0 in IDLE and RESP. No TCK edges occur while a response is waiting.
- `rsp_valid` holds until accepted. A new command cannot be accepted in the same cycle as the response (`cmd_ready` is still 0).
- `rst_n` asserted mid-operation: outputs return to reset values asynchronously and the in-flight command is discarded. The TAP position is then unknown, so op 00 is required next.

## Configuration
- `JTAG_MASTER_RUNTEST_EN` defined: op 11 behaves as specified above.
- `JTAG_MASTER_RUNTEST_EN` undefined:
  - Op 11 is a no-op: no TCK edges.
  - `rsp_valid` = 1 on the cycle after accept, with `rsp_data` = 0.
  - The RUN state and its counter are not built.

## Test plan
- After `rst_n`: op 00 → 7 TCK cycles with TMS = 1,1,1,1,1,1,0 and `rsp_data` = 0. Then op 10, len 32, data 0 → `rsp_data` = 32'hDEADBEEF (IDCODE).
- CLK_DIV = 2: op 10, len 32 → `rsp_valid` exactly 148 clk after accept. `tms`/`tdi` never change while `tck` = 1.
- Op 01, len 5, data 5'b11111 → `rsp_data` = 5'b00001 (IR capture value). Then op 10, len 8, data 8'hA5 (bypass) → `rsp_data` = 8'h4A.
- `rsp_ready` held 0 for 20 clk → `rsp_valid` and `rsp_data` stable, `tck` stays 0, `cmd_ready` = 0 throughout.
- `rst_n` pulsed during the SHIFT of an op 10, len 32 → outputs reset immediately. Op 00 then op 10, len 32 → 32'hDEADBEEF.
- `cmd_len` = 0 and `cmd_len` = 40 on op 10 → 37 TCK cycles each (32-bit shift).
